// File: rtl/tlc_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tlc_phase_sequencer
//
// Timing front-end for the four-way traffic-light controller. Steps the
// phase index through 0..5 with a programmable dwell per phase. It emits a
// one-cycle advance strobe when a new phase becomes visible, so the lamp
// decoder downstream only changes phase when the dwell expires.
//
// Phase green sets (approach l1..l4 = det/demand bit 0..3):
//   0 = l1+l3, 1 = l2+l4, 2 = l1, 3 = l2, 4 = l3, 5 = l4
//
// Parameters:
//   TICK_DIV     clk cycles per timing tick (1..65536)
//   DUAL_TICKS   dwell in ticks of phases 0 and 1 (1..255)
//   SINGLE_TICKS dwell in ticks of phases 2..5 (1..255)
//   MIN_TICKS    shortened dwell of an undemanded single phase
//                (1..255, <= SINGLE_TICKS); used only with the option below
//
// Ports:
//   clk     in   system clock, all state on rising edge
//   rst     in   asynchronous, active-high reset
//   det     in   [3:0] vehicle detectors, synchronous level
//   hold    in   freeze timing while high (demand latch keeps updating)
//   phase   out  [2:0] current phase 0..5
//   adv     out  one-cycle strobe, high in first cycle of a new phase
//   remain  out  [7:0] ticks left in the current phase
//   demand  out  [3:0] latched demand per approach
//
// Build option:
//   TLC_DEMAND_SKIP_EN  when defined, a single phase (2..5) whose approach
//                       has no latched demand at load time gets MIN_TICKS
//                       instead of SINGLE_TICKS. When undefined, demand is
//                       still latched and visible but does not affect timing.
// ---------------------------------------------------------------------------
module tlc_phase_sequencer #(
  parameter int TICK_DIV     = 4,
  parameter int DUAL_TICKS   = 3,
  parameter int SINGLE_TICKS = 2,
  parameter int MIN_TICKS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] det,
  input  logic       hold,
  output logic [2:0] phase,
  output logic       adv,
  output logic [7:0] remain,
  output logic [3:0] demand
);

  // Terminal prescaler value. TICK_DIV = 65536 maps onto 16'hFFFF.
  localparam logic [15:0] PRE_MAX   = 16'(TICK_DIV - 1);
  localparam logic [7:0]  DUAL_LD   = 8'(DUAL_TICKS);
  localparam logic [7:0]  SINGLE_LD = 8'(SINGLE_TICKS);
  localparam logic [7:0]  MIN_LD    = 8'(MIN_TICKS);

`ifdef TLC_DEMAND_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    PH_L13 = 3'd0,
    PH_L24 = 3'd1,
    PH_L1  = 3'd2,
    PH_L2  = 3'd3,
    PH_L3  = 3'd4,
    PH_L4  = 3'd5
  } phase_t;

  phase_t      state;
  phase_t      state_nxt;

  logic [15:0] pre;
  logic [15:0] pre_nxt;
  logic [7:0]  remain_q;
  logic [7:0]  remain_nxt;
  logic [7:0]  dwell_nxt;
  logic        adv_q;
  logic        adv_nxt;
  logic [3:0]  demand_q;
  logic [3:0]  demand_nxt;
  logic [3:0]  green_cur;
  logic [3:0]  green_nxt;
  logic        tick;
  logic        expire;

  // Approaches that are green in a given phase.
  function automatic logic [3:0] green_mask(input phase_t p);
    case (p)
      PH_L13:  green_mask = 4'b0101;
      PH_L24:  green_mask = 4'b1010;
      PH_L1:   green_mask = 4'b0001;
      PH_L2:   green_mask = 4'b0010;
      PH_L3:   green_mask = 4'b0100;
      PH_L4:   green_mask = 4'b1000;
      default: green_mask = 4'b0000;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Timing strobes
  // -------------------------------------------------------------------------
  always_comb begin
    tick   = (pre == PRE_MAX) && !hold;
    expire = tick && (remain_q == 8'd1);
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PH_L13;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic (advances only when the dwell expires)
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (expire) begin
      case (state)
        PH_L13:  state_nxt = PH_L24;
        PH_L24:  state_nxt = PH_L1;
        PH_L1:   state_nxt = PH_L2;
        PH_L2:   state_nxt = PH_L3;
        PH_L3:   state_nxt = PH_L4;
        PH_L4:   state_nxt = PH_L13;
        default: state_nxt = PH_L13;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output logic
  // -------------------------------------------------------------------------
  always_comb begin
    phase     = state;
    green_cur = green_mask(state);
    green_nxt = green_mask(state_nxt);
  end

  // -------------------------------------------------------------------------
  // Datapath next-state: prescaler, dwell counter, strobe, demand latch
  // -------------------------------------------------------------------------
  always_comb begin
    // Prescaler freezes while held so release resumes mid-tick.
    pre_nxt = pre;
    if (!hold) begin
      if (pre == PRE_MAX) begin
        pre_nxt = '0;
      end else begin
        pre_nxt = pre + 16'd1;
      end
    end

    // Dwell of the phase being entered. The demand used here is the value
    // from before this edge's latch update, so demand arriving on the
    // advance edge itself cannot lengthen the new phase.
    if (state_nxt == PH_L13 || state_nxt == PH_L24) begin
      dwell_nxt = DUAL_LD;
    end else if (SKIP_EN && ((demand_q & green_nxt) == 4'b0000)) begin
      dwell_nxt = MIN_LD;
    end else begin
      dwell_nxt = SINGLE_LD;
    end

    remain_nxt = remain_q;
    if (expire) begin
      remain_nxt = dwell_nxt;
    end else if (tick) begin
      remain_nxt = remain_q - 8'd1;
    end

    adv_nxt = expire;

    // Clear the bits of the phase being left, then OR in detectors:
    // a detector active on the advance edge keeps its bit set.
    demand_nxt = (demand_q & ~(expire ? green_cur : 4'b0000)) | det;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      remain_q <= DUAL_LD;
      adv_q    <= 1'b0;
      demand_q <= '0;
    end else begin
      pre      <= pre_nxt;
      remain_q <= remain_nxt;
      adv_q    <= adv_nxt;
      demand_q <= demand_nxt;
    end
  end

  assign remain = remain_q;
  assign adv    = adv_q;
  assign demand = demand_q;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tlc_phase_sequencer
//
// Drives tlc_phase_sequencer with directed and random det/hold patterns and
// compares every cycle against a cycle-budget model: each phase is a number
// of clk cycles (dwell * TICK_DIV) counted down by unheld cycles, and the
// remaining tick count is derived arithmetically from that budget. A second
// instance with TICK_DIV = 1 and unit dwells covers the fastest walk.
// ---------------------------------------------------------------------------
module tb_tlc_phase_sequencer;

  localparam int T  = 4;
  localparam int DU = 3;
  localparam int SI = 2;
  localparam int MN = 1;

  logic       clk;
  logic       rst;
  logic [3:0] det;
  logic       hold;
  logic [2:0] phase;
  logic       adv;
  logic [7:0] remain;
  logic [3:0] demand;

  logic       rst_f;
  logic [2:0] phase_f;
  logic       adv_f;
  logic [7:0] remain_f;
  logic [3:0] demand_f;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_phase;
  int         m_left;    // unheld clk cycles until the next advance
  bit         m_adv;
  logic [3:0] m_demand;
  int         edges;     // edges since last reset release

  logic [3:0] greens [6] = '{4'b0101, 4'b1010, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  tlc_phase_sequencer #(
    .TICK_DIV(T), .DUAL_TICKS(DU), .SINGLE_TICKS(SI), .MIN_TICKS(MN)
  ) u_dut (
    .clk(clk), .rst(rst), .det(det), .hold(hold),
    .phase(phase), .adv(adv), .remain(remain), .demand(demand)
  );

  tlc_phase_sequencer #(
    .TICK_DIV(1), .DUAL_TICKS(1), .SINGLE_TICKS(1), .MIN_TICKS(1)
  ) u_fast (
    .clk(clk), .rst(rst_f), .det(4'b0000), .hold(1'b0),
    .phase(phase_f), .adv(adv_f), .remain(remain_f), .demand(demand_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dwell_of(input int p, input logic [3:0] dem);
    if (p < 2) return DU;
`ifdef TLC_DEMAND_SKIP_EN
    if ((dem & greens[p]) == 4'b0000) return MN;
`endif
    return SI;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_left   = DU * T;
    m_adv    = 1'b0;
    m_demand = 4'b0000;
    edges    = 0;
  endtask

  task automatic model_edge(input logic [3:0] d, input logic h);
    logic [3:0] clr;
    int nxt;
    clr   = 4'b0000;
    m_adv = 1'b0;
    if (!h) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        clr     = greens[m_phase];
        nxt     = (m_phase + 1) % 6;
        m_left  = dwell_of(nxt, m_demand) * T;
        m_phase = nxt;
        m_adv   = 1'b1;
      end
    end
    m_demand = (m_demand & ~clr) | d;
    edges++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".phase"},  int'(phase),  m_phase);
    chk({tag, ".remain"}, int'(remain), (m_left + T - 1) / T);
    chk({tag, ".adv"},    int'(adv),    int'(m_adv));
    chk({tag, ".demand"}, int'(demand), int'(m_demand));
  endtask

  // Drive inputs away from the edge, clock once, update model, check.
  task automatic step(input logic [3:0] d, input logic h, input string tag);
    det  = d;
    hold = h;
    @(posedge clk);
    model_edge(d, h);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst  = 1'b0;
    det  = 4'b0000;
    hold = 1'b0;
  endtask

  // Step with idle inputs until adv is seen, then compare the edge count.
  task automatic run_until_adv(input string tag, input int exp_edges);
    int n = 0;
    do begin
      step(4'b0000, 1'b0, tag);
      n++;
    end while (!adv && n < 1000);
    chk({tag, ".edges"}, edges, exp_edges);
  endtask

  initial begin
    rst   = 1'b1;
    rst_f = 1'b1;
    det   = 4'b0000;
    hold  = 1'b0;
    model_reset();

    // Reset values and first advance after DUAL_TICKS * TICK_DIV edges.
    do_reset();
    run_until_adv("first_adv", DU * T);
    chk("first_adv.phase", int'(phase), 1);
    for (int i = 0; i < 60; i++) step(4'b0000, 1'b0, "idle_cycle");

    // Hold 10 cycles from phase 0 with remain=2, pre=1.
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, "pre_hold");
    chk("pre_hold.remain", int'(remain), 2);
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b1, "hold");
    chk("hold.remain", int'(remain), 2);
    run_until_adv("held_adv", DU * T + 10);

    // det[0] held across the end of phase 2: demand[0] survives the clear.
    do_reset();
    for (int i = 0; i < 29; i++) step(4'b0000, 1'b0, "to_ph2_end");
    for (int i = 0; i < 5; i++) step(4'b0001, 1'b0, "set_wins");
    chk("set_wins.demand0", int'(demand[0]), 1);

    // det[2] pulsed during phase 0, then walk one full cycle.
    do_reset();
    step(4'b0100, 1'b0, "det2_pulse");
    for (int i = 0; i < 60; i++) step(4'b0000, 1'b0, "det2_cycle");

    // Async reset during phase 3 with remain=1.
    do_reset();
    for (int i = 0; i < 37; i++) step(4'b0000, 1'b0, "to_ph3");
    chk("ph3.phase", int'(phase), 3);
    chk("ph3.remain", int'(remain), 1);
    rst = 1'b1;
    #2;
    model_reset();
    check_all("async_rst");
    #1;
    rst = 1'b0;
    run_until_adv("post_rst_adv", DU * T);

    // Random detectors with occasional hold.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step(4'($urandom), ($urandom_range(0, 7) == 0), "random");
    end

    // Fastest configuration: advance every cycle, phase walks and wraps.
    @(negedge clk);
    rst_f = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      chk("fast.adv", int'(adv_f), 1);
      chk("fast.phase", int'(phase_f), i % 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlc_phase_sequencer.md
# tlc_phase_sequencer

Timing front-end for the four-way traffic-light controller. Generates the phase index (0-5) and a one-cycle advance strobe with a programmable dwell per phase, so the lamp decoder changes phase only when dwell expires rather than on every clock. Latches per-approach vehicle demand and supports a hold (emergency/manual freeze). Sits directly upstream of the lamp-decoding controller, which consumes `phase`/`adv`.

## Interface
- `TICK_DIV`, 4, clk cycles per timing tick (1..65536)
- `DUAL_TICKS`, 3, dwell in ticks of phases 0 and 1 (1..255)
- `SINGLE_TICKS`, 2, dwell in ticks of phases 2-5 (1..255)
- `MIN_TICKS`, 1, shortened dwell for an undemanded single phase (1..255, ≤ SINGLE_TICKS)

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `det`  in  4  vehicle detectors, bit i = approach l(i+1), synchronous level
- `hold`  in  1  freeze timing while high
- `phase`  out  3  current phase 0..5
- `adv`  out  1  one-cycle strobe, high in the first cycle a new `phase` value is visible
- `remain`  out  8  ticks left in current phase
- `demand`  out  4  latched demand per approach

## Operation
- Phase green sets (lamp encoding RED=1, GREEN=0 downstream): 0 = l1+l3, 1 = l2+l4, 2 = l1, 3 = l2, 4 = l3, 5 = l4. Sequence 0→1→2→3→4→5→0; values 6,7 never produced.
- Prescaler `pre` (16 bit): counts 0..TICK_DIV-1, wraps to 0; `tick` = (pre == TICK_DIV-1) & !hold. TICK_DIV=1 → tick every unheld cycle.
- Dwell counter `remain`: on tick, if remain > 1, decrement; if remain == 1, advance: phase ← next, remain ← dwell(next), adv ← 1 for next cycle only.
- dwell(p): DUAL_TICKS for p∈{0,1}; SINGLE_TICKS for p∈{2..5}, subject to Configuration.
- Demand latch: demand[i] set on any cycle with det[i]=1; cleared at the advance edge leaving a phase in which approach i was green. Set and clear on the same edge → set wins (stays 1).
- hold=1: pre, remain, phase frozen; adv held 0; demand latch still updates. hold release resumes from the frozen pre/remain values, no restart.
- States are the six phase values; no other FSM state.

## Timing
- Reset values: phase=0, remain=DUAL_TICKS, pre=0, adv=0, demand=0. Asserting rst mid-phase returns all of these immediately (async), discarding dwell progress.
- First advance after reset release: edge number DUAL_TICKS×TICK_DIV (counting first edge after release as 1); adv high for the following cycle.
- Phase duration = dwell(p)×TICK_DIV clk cycles when unheld; held cycles add 1:1.
- adv is registered; phase, remain, adv update on the same edge. `demand` reflects det with one-cycle latency.
- dwell(next) evaluated with demand values before that edge's update.

## Configuration
- `TLC_DEMAND_SKIP_EN` defined: a single phase (2-5) whose approach demand bit is 0 at load time gets MIN_TICKS instead of SINGLE_TICKS; demand arriving mid-phase does not lengthen it. Dual phases unaffected.
- Not defined: all single phases use SINGLE_TICKS; demand latch still present and observable, with no effect on timing.

## Test plan
- Defaults, det=0, hold=0, macro off: adv pulses after edges 12, 24, 32, 40, 48, 56; phase 1,2,3,4,5,0; full cycle 56 clk.
- Macro on, det=0: single phases last 4 clk; full cycle 40 clk; with det[2] pulsed once during phase 0, phase 4 lasts 8 clk and demand[2] clears when phase 4 ends.
- hold high for 10 cycles mid-phase 0 (remain=2, pre=1): phase, remain, pre unchanged during hold; first adv 10 cycles later than unheld run.
- det[0] held high across the end of phase 2: demand[0] remains 1 after the advance (set wins).
- rst pulsed during phase 3, remain=1: immediately phase=0, remain=3, adv=0, demand=0; next adv after 12 edges.
- TICK_DIV=1, all dwell=1: adv every cycle, phase walks 0..5 and wraps to 0.
